life_led_scanner: RTL and testbench
===================================

Name: life_led_scanner

Overview:
Downstream consumer of the 8x8 game-of-life grid produced by MATRIX. It double-buffers each new generation and drives a multiplexed LED matrix, one row at a time.
- Scanning: one-hot row drive, active-low column sinks, with a blanking gap between rows to suppress ghosting.
- Tear-free updates: new generations are promoted to the display only at frame boundaries, so a frame never mixes two generations.

Parameters:
ROWS, 8, grid rows / LED row lines
COLS, 8, grid columns / LED column lines
DWELL_CYCLES, 1000, clk cycles each row is driven (>=1)
BLANK_CYCLES, 8, clk cycles all outputs blanked before each row (>=1)

Ports:
clk  input  1  system clock, rising edge
_rst  input  1  reset; asynchronous, active-low
grid_in  input  ROWS*COLS  flattened generation; cell (r,c) at bit r*COLS+c, 1 = alive
grid_valid  input  1  upstream offers grid_in this cycle
grid_ready  output  1  pending buffer empty; capture occurs on grid_valid && grid_ready
row_out  output  ROWS  one-hot row drive, active-high; all-zero when blanked
col_n  output  COLS  column sinks, active-low; col_n[c] = ~cell(row,c); all-ones when blanked
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async assert, sync release): state=BLANK, row_idx=0, timer=0, display buffer=0, pending buffer=0, pending_full=0.
  - Outputs during and after reset: row_out=0, col_n=all ones, grid_ready=1, frame_done=0.
  - Reset mid-operation aborts the scan immediately and clears both buffers.
- State machine, two states:
  - BLANK: hold for BLANK_CYCLES cycles, then go to DRIVE.
  - DRIVE: hold for DWELL_CYCLES cycles, then go to BLANK and advance row_idx.
- Timer: counts 0..N-1 in each state. Width = $clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1).
- Outputs: registered, decoded from state/row_idx/display only.
  - In DRIVE: row_out = 1<<row_idx, col_n = ~display[row_idx].
  - In BLANK: row_out=0, col_n=all ones.
  - Never more than one row_out bit high.
- Row wrap: on the last DRIVE cycle of row ROWS-1, the next edge does all of:
  - row_idx←0, state←BLANK, frame_done←1 for exactly one cycle;
  - if pending_full: display←pending, pending_full←0.
- Frame period = ROWS*(BLANK_CYCLES+DWELL_CYCLES) cycles; the first frame after reset displays all-dark.
- Handshake:
  - grid_ready = !pending_full (registered).
  - Capture edge: pending←grid_in, pending_full←1.
  - grid_valid while grid_ready=0 is ignored; the upstream holds its data until accepted. No overwrite of pending.
  - Capture and promotion cannot coincide: promotion requires pending_full, which implies ready=0.
  - grid_ready returns to 1 the cycle after promotion.
- No tearing: a capture mid-frame does not alter the rows still to be drawn in the current frame. The new generation appears starting at row 0 of the next frame.
- grid_in is sampled only on the capture edge; at all other times it is a don't-care.

Decomposition:
- Shared package life_pkg holds:
  - default ROWS/COLS constants;
  - scan state enum {BLANK, DRIVE};
  - cell-index function idx(r,c)=r*COLS+c, also used by MATRIX and benches.
- One natural sub-module, life_row_timer: loadable down-counter with a terminal-count flag. It serves both the BLANK and DRIVE intervals.
- The FSM, buffers and output decode stay in life_led_scanner.

Test Plan (DWELL_CYCLES=4, BLANK_CYCLES=2, 8x8; frame = 48 cycles):
1. Assert _rst low asynchronously, between clock edges -> immediately row_out=00, col_n=FF, grid_ready=1, frame_done=0. Hold 3 cycles; release -> first DRIVE of row 0 after 2 blank cycles shows col_n=FF (empty display).
2. Idle run -> frame_done pulses exactly 48 cycles apart; row_out walks 01,02,...,80, each high for 4 cycles, separated by 2 cycles of 00.
3. Load glider (row0=0x02, row1=0x04, row2=0x07, rest 0) with one valid strobe -> grid_ready drops the next cycle.
   - After the next frame_done, rows 0..2 drive col_n=FD, FB, F8; the rest FF.
   - grid_ready returns to 1 one cycle after promotion.
4. Two back-to-back offers: A accepted, B held valid -> B ignored until ready=1. B is captured the cycle after A's promotion and displayed one frame later; A is never overwritten.
5. Capture new grid (all 0xFF) during DRIVE of row 4 -> rows 4..7 of that frame still show the old data. The next frame shows col_n=00 on every row.
6. Assert _rst during DRIVE of row 3 with pending_full=1 -> outputs blank at once. After release, grid_ready=1 and the display is dark (both buffers cleared).

Source files
------------

// File: rtl/life_pkg.sv
// Shared definitions for the game-of-life grid producer, its LED scanner and
// their benches: default grid size, scan state encoding and cell indexing.
package life_pkg;

  localparam int LIFE_ROWS = 8;
  localparam int LIFE_COLS = 8;

  // Scanner alternates between a blanking gap and driving one row.
  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_DRIVE = 1'b1
  } scan_state_e;

  // Bit position of cell (r,c) inside a flattened generation.
  function automatic int idx(input int r, input int c, input int cols = LIFE_COLS);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/life_row_timer.sv
// Interval timer for the LED scanner: a loadable down-counter that parks at
// zero and flags terminal count there. Loading N-1 yields an N-cycle interval.
module life_row_timer #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] count_q, count_d;

  // Reload on request, otherwise count down and hold at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register; reset value makes the first interval after reset full length.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/life_led_scanner.sv
// Multiplexed LED matrix driver for the game-of-life grid. Each accepted
// generation waits in a pending buffer and is promoted to the display buffer
// only at a frame boundary, so a frame never mixes two generations.
//
// Handshake: grid_valid/grid_ready. A transfer happens on a rising edge where
// both are high; grid_ready is a registered !pending_full, upstream holds
// grid_in stable while grid_valid is high and grid_ready is low, and grid_in
// is ignored on every other edge.
module life_led_scanner
  import life_pkg::*;
#(
  parameter int ROWS         = LIFE_ROWS,
  parameter int COLS         = LIFE_COLS,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 _rst,
  input  logic [ROWS*COLS-1:0] grid_in,
  input  logic                 grid_valid,
  output logic                 grid_ready,
  output logic [ROWS-1:0]      row_out,
  output logic [COLS-1:0]      col_n,
  output logic                 frame_done,
  output scan_state_e          dbg_state_o
);

  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  localparam logic [TW-1:0] DWELL_LD = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LD = TW'(BLANK_CYCLES - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  scan_state_e             state_q, state_d;
  logic [RW-1:0]           row_idx_q, row_idx_d;
  logic [ROWS*COLS-1:0]    display_q, display_d;
  logic [ROWS*COLS-1:0]    pending_q, pending_d;
  logic                    pending_full_q, pending_full_d;

  logic [ROWS-1:0]         row_out_q, row_out_d;
  logic [COLS-1:0]         col_n_q, col_n_d;
  logic                    grid_ready_q, grid_ready_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tc;
  logic [TW-1:0]           load_val;

  // Timer reloads at every terminal count with the length of the next interval.
  life_row_timer #(
    .W       (TW),
    .RST_VAL (BLANK_LD)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (_rst),
    .load_i     (tc),
    .load_val_i (load_val),
    .tc_o       (tc)
  );

  // Next state: scan sequencing, row advance, frame-boundary promotion, capture.
  always_comb begin
    state_d        = state_q;
    row_idx_d      = row_idx_q;
    display_d      = display_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    frame_done_d   = 1'b0;
    load_val       = BLANK_LD;

    case (state_q)
      SCAN_BLANK: begin
        load_val = DWELL_LD;
        if (tc) begin
          state_d = SCAN_DRIVE;
        end
      end
      SCAN_DRIVE: begin
        load_val = BLANK_LD;
        if (tc) begin
          state_d = SCAN_BLANK;
          if (row_idx_q == LAST_ROW) begin
            row_idx_d    = '0;
            frame_done_d = 1'b1;
            if (pending_full_q) begin
              display_d      = pending_q;
              pending_full_d = 1'b0;
            end
          end else begin
            row_idx_d = row_idx_q + RW'(1);
          end
        end
      end
      default: begin
        state_d = SCAN_BLANK;
      end
    endcase

    // Promotion needs pending_full, capture needs ready (= !pending_full),
    // so the two never act on the same edge.
    if (grid_valid && grid_ready_q) begin
      pending_d      = grid_in;
      pending_full_d = 1'b1;
    end
  end

  // Output decode from the next-state values so registered outputs line up
  // with the state they describe.
  always_comb begin
    row_out_d    = '0;
    col_n_d      = '1;
    grid_ready_d = !pending_full_d;
    if (state_d == SCAN_DRIVE) begin
      for (int r = 0; r < ROWS; r++) begin
        if (row_idx_d == RW'(r)) begin
          row_out_d[r] = 1'b1;
          col_n_d      = ~display_d[idx(r, 0, COLS) +: COLS];
        end
      end
    end
  end

  // Scan state and frame buffers.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q        <= SCAN_BLANK;
      row_idx_q      <= '0;
      display_q      <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_idx_q      <= row_idx_d;
      display_q      <= display_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
    end
  end

  // Registered outputs; reset blanks the matrix immediately.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      row_out_q    <= '0;
      col_n_q      <= '1;
      grid_ready_q <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      row_out_q    <= row_out_d;
      col_n_q      <= col_n_d;
      grid_ready_q <= grid_ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row_out     = row_out_q;
  assign col_n       = col_n_q;
  assign grid_ready  = grid_ready_q;
  assign frame_done  = frame_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_life_led_scanner.sv
// Bench for life_led_scanner with DWELL=4, BLANK=2 on an 8x8 grid.
// Reference model: a frame timeline (cycle count since reset) plus the two
// grid buffers; expected outputs are derived from the position in the frame.
module tb_life_led_scanner;
  import life_pkg::*;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = DWELL + BLANK;
  localparam int FRAME = ROWS * SLOT;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [ROWS*COLS-1:0] grid_in;
  logic                 grid_valid;
  logic                 grid_ready;
  logic [ROWS-1:0]      row_out;
  logic [COLS-1:0]      col_n;
  logic                 frame_done;
  scan_state_e          dbg_state;

  always #5 clk = ~clk;

  life_led_scanner #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk         (clk),
    ._rst        (rst_n),
    .grid_in     (grid_in),
    .grid_valid  (grid_valid),
    .grid_ready  (grid_ready),
    .row_out     (row_out),
    .col_n       (col_n),
    .frame_done  (frame_done),
    .dbg_state_o (dbg_state)
  );

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int               t;            // cycles since reset release
  logic [COLS-1:0]  m_disp [ROWS];
  logic [63:0]      m_pend;
  bit               m_full;

  // {row_out[7:0], col_n[7:0], ready, frame_done, driving}
  logic [18:0] exp_q[$];

  task automatic model_reset();
    t = 0;
    for (int r = 0; r < ROWS; r++) m_disp[r] = '0;
    m_pend = '0;
    m_full = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [63:0] g);
    bit old_full;
    old_full = m_full;
    t++;
    if ((t % FRAME) == 0 && old_full) begin
      for (int r = 0; r < ROWS; r++) m_disp[r] = m_pend[idx(r, 0) +: COLS];
      m_full = 1'b0;
    end
    if (v && !old_full) begin
      m_pend = g;
      m_full = 1'b1;
    end
  endtask

  function automatic logic [18:0] expect_now();
    int pos, r, w;
    logic [7:0] e_row, e_col;
    logic e_drive;
    pos = t % FRAME;
    r   = pos / SLOT;
    w   = pos % SLOT;
    if (w < BLANK) begin
      e_row = 8'h00; e_col = 8'hFF; e_drive = 1'b0;
    end else begin
      e_row = 8'(1 << r); e_col = ~m_disp[r]; e_drive = 1'b1;
    end
    return {e_row, e_col, ~m_full, (t != 0 && pos == 0), e_drive};
  endfunction

  task automatic compare_outputs();
    logic [18:0] e;
    e = exp_q.pop_front();
    check("row_out",    row_out,                  e[18:11]);
    check("col_n",      col_n,                    e[10:3]);
    check("grid_ready", grid_ready,               e[2]);
    check("frame_done", frame_done,               e[1]);
    check("state",      dbg_state == SCAN_DRIVE,  e[0]);
  endtask

  // ---------------- drivers ----------------
  task automatic step(input bit v, input logic [63:0] g);
    grid_valid = v;
    grid_in    = g;
    @(posedge clk);
    #1;
    model_edge(v, g);
    exp_q.push_back(expect_now());
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, {$urandom, $urandom});
  endtask

  // Offer one generation and hold it until it is taken.
  task automatic offer(input logic [63:0] g);
    bit was_free;
    int n;
    n = 0;
    forever begin
      was_free = !m_full;
      step(1'b1, g);
      n++;
      if (was_free) break;
      if (n > 3 * FRAME) begin
        check("offer_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic advance_to(input int lo, input int hi);
    int n;
    n = 0;
    while (!((t % FRAME) >= lo && (t % FRAME) <= hi)) begin
      step(1'b0, {$urandom, $urandom});
      n++;
      if (n > 2 * FRAME) begin
        check("advance_timeout", 1, 0);
        break;
      end
    end
  endtask

  // Assert reset between edges, check the immediate blanking, hold, release.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_row_out",    row_out,    8'h00);
    check("rst_col_n",      col_n,      8'hFF);
    check("rst_grid_ready", grid_ready, 1'b1);
    check("rst_frame_done", frame_done, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    exp_q.push_back(expect_now());
    compare_outputs();
  endtask

  // ---------------- stimulus ----------------
  logic [63:0] glider;
  logic [63:0] cur_g;
  bit          cur_v;

  initial begin
    rst_n      = 1'b1;
    grid_valid = 1'b0;
    grid_in    = '0;
    model_reset();
    @(posedge clk);

    // Reset and an idle run: dark display, frame_done every FRAME cycles.
    async_reset();
    idle(2 * FRAME + 5);

    // Glider, single strobe; appears from the next frame.
    glider = 64'h0000_0000_0007_0402;
    advance_to(10, 12);
    offer(glider);
    idle(2 * FRAME);

    // Back-to-back offers: B is held until A has been promoted.
    offer({$urandom, $urandom});
    offer({$urandom, $urandom});
    idle(2 * FRAME);

    // Capture during DRIVE of row 4: the rest of this frame keeps old data.
    advance_to(4 * SLOT + BLANK, 4 * SLOT + SLOT - 1);
    offer('1);
    idle(2 * FRAME);

    // Reset while row 3 is driven and a generation is pending.
    advance_to(1, 3);
    offer({$urandom, $urandom});
    advance_to(3 * SLOT + BLANK, 3 * SLOT + SLOT - 1);
    check("pending_before_rst", grid_ready, 1'b0);
    async_reset();
    idle(FRAME + 6);

    // Random traffic; an unaccepted offer keeps its data.
    cur_v = 1'b0;
    cur_g = '0;
    for (int i = 0; i < 8 * FRAME; i++) begin
      if (!(cur_v && m_full)) begin
        cur_v = ($urandom_range(0, 7) == 0);
        cur_g = {$urandom, $urandom};
      end
      step(cur_v, cur_g);
    end
    idle(FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
